// File: rtl/d_cache_ctrl_if.sv
// Bus bundle for the data cache controller: the CPU load/store side and
// the word-transfer port to next-level memory.
interface d_cache_ctrl_if;
   logic        rd_req;
   logic        wr_req;
   logic [31:0] addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        miss;
   logic        mem_rd_req;
   logic        mem_wr_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic [31:0] mem_rd_data;
   logic        mem_gnt;

   modport slave (
      input  rd_req, wr_req, addr, wr_data, mem_rd_data, mem_gnt,
      output rd_data, miss, mem_rd_req, mem_wr_req, mem_addr, mem_wr_data
   );

   modport master (
      output rd_req, wr_req, addr, wr_data, mem_rd_data, mem_gnt,
      input  rd_data, miss, mem_rd_req, mem_wr_req, mem_addr, mem_wr_data
   );
endinterface

// File: rtl/d_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines x 4 words.
// Misses stall the pipeline while a dirty victim is written back and the line refilled.
module d_cache_ctrl (
   input logic           clk,
   input logic           rst,
   d_cache_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;

   state_t      state;
   state_t      next_state;
   logic [1:0]  cnt;
   logic [31:0] data [8][4];
   logic [24:0] tags [8];
   logic [7:0]  valid;
   logic [7:0]  dirty;

   logic [2:0]  idx;
   logic [1:0]  off;
   logic [24:0] tag;
   logic        req;
   logic        hit;
   logic        last_word;

   assign idx       = bus.addr[6:4];
   assign off       = bus.addr[3:2];
   assign tag       = bus.addr[31:7];
   assign req       = bus.rd_req | bus.wr_req;
   assign hit       = req & valid[idx] & (tags[idx] == tag);
   assign last_word = bus.mem_gnt & (cnt == 2'd3);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // The word counter only moves on a grant, so a slow memory simply holds the current beat.
   always_ff @(posedge clk) begin
      if (rst)                                     cnt <= 2'd0;
      else if (state == IDLE)                      cnt <= 2'd0;
      else if (bus.mem_gnt)                        cnt <= cnt + 2'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
         dirty <= '0;
      end else if (state == IDLE && hit && bus.wr_req) begin
         dirty[idx] <= 1'b1;
      end else if (state == REFILL && last_word) begin
         valid[idx] <= 1'b1;
         dirty[idx] <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == IDLE && hit && bus.wr_req)
            data[idx][off] <= bus.wr_data;
         else if (state == REFILL && bus.mem_gnt)
            data[idx][cnt] <= bus.mem_rd_data;
         if (state == REFILL && last_word)
            tags[idx] <= tag;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (req && !hit)
                     next_state = (valid[idx] && dirty[idx]) ? WB : REFILL;
         WB:      if (last_word) next_state = REFILL;
         REFILL:  if (last_word) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      bus.rd_data     = data[idx][off];
      bus.miss        = 1'b0;
      bus.mem_rd_req  = 1'b0;
      bus.mem_wr_req  = 1'b0;
      bus.mem_addr    = 32'd0;
      bus.mem_wr_data = 32'd0;
      case (state)
         IDLE: bus.miss = req & ~hit;
         WB: begin
            bus.miss        = 1'b1;
            bus.mem_wr_req  = 1'b1;
            bus.mem_addr    = {tags[idx], idx, cnt, 2'b00};
            bus.mem_wr_data = data[idx][cnt];
         end
         REFILL: begin
            bus.miss       = 1'b1;
            bus.mem_rd_req = 1'b1;
            bus.mem_addr   = {tag, idx, cnt, 2'b00};
         end
         default: bus.miss = 1'b0;
      endcase
   end
endmodule

// File: tb/tb_d_cache_ctrl.sv
// Directed bench for d_cache_ctrl: a memory model that returns word=address,
// with hand-computed miss latencies, transfer addresses and writeback data.
module tb_d_cache_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;

   d_cache_ctrl_if bus ();

   d_cache_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   int          missCycles;
   int          rdCount;
   int          wrCount;
   logic        bothSeen;
   logic [31:0] lastRdData;
   logic [31:0] rdAddrs [8];
   logic [31:0] wrAddrs [8];
   logic [31:0] wrData  [8];
   logic [31:0] expWb   [4];

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
      end
   endtask

   // Holds a CPU request until miss drops, granting every lowCycles+1 cycles while
   // logging each transferred word; called and returning at posedge+1.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] wd, input int lowCycles);
      int waitCnt;
      int cyc;
      missCycles = 0;
      rdCount    = 0;
      wrCount    = 0;
      bothSeen   = 1'b0;
      waitCnt    = 0;
      bus.rd_req  = rd;
      bus.wr_req  = wr;
      bus.addr    = a;
      bus.wr_data = wd;
      for (cyc = 0; cyc < 100; cyc++) begin
         #1;
         bus.mem_rd_data = bus.mem_addr;
         if (bus.mem_rd_req || bus.mem_wr_req) begin
            if (waitCnt == lowCycles) begin
               bus.mem_gnt = 1'b1;
               waitCnt     = 0;
            end else begin
               bus.mem_gnt = 1'b0;
               waitCnt++;
            end
         end else begin
            bus.mem_gnt = 1'b1;
         end
         #1;
         if (bus.mem_rd_req && bus.mem_wr_req) bothSeen = 1'b1;
         if (bus.mem_gnt && bus.mem_rd_req && rdCount < 8) begin
            rdAddrs[rdCount] = bus.mem_addr;
            rdCount++;
         end
         if (bus.mem_gnt && bus.mem_wr_req && wrCount < 8) begin
            wrAddrs[wrCount] = bus.mem_addr;
            wrData[wrCount]  = bus.mem_wr_data;
            wrCount++;
         end
         lastRdData = bus.rd_data;
         if (!bus.miss) break;
         missCycles++;
         @(posedge clk);
         #1;
      end
      if (cyc >= 100) checkOutput("timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      bus.rd_req  = 1'b0;
      bus.wr_req  = 1'b0;
      bus.mem_gnt = 1'b0;
   endtask

   task automatic checkRefill(input string tag, input logic [31:0] base);
      checkOutput({tag, "_rd_count"}, rdCount, 4);
      for (int i = 0; i < 4; i++)
         checkOutput({tag, "_rd_addr"}, rdAddrs[i], base + 32'(4 * i));
   endtask

   task automatic checkWriteback(input string tag, input logic [31:0] base);
      checkOutput({tag, "_wr_count"}, wrCount, 4);
      for (int i = 0; i < 4; i++) begin
         checkOutput({tag, "_wr_addr"}, wrAddrs[i], base + 32'(4 * i));
         checkOutput({tag, "_wr_data"}, wrData[i], expWb[i]);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bus.rd_req      = 1'b0;
      bus.wr_req      = 1'b0;
      bus.addr        = 32'd0;
      bus.wr_data     = 32'd0;
      bus.mem_rd_data = 32'd0;
      bus.mem_gnt     = 1'b0;
      rst             = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("reset_miss", bus.miss, 0);
      checkOutput("reset_mem_rd", bus.mem_rd_req, 0);
      checkOutput("reset_mem_wr", bus.mem_wr_req, 0);

      // Clean miss after reset: four-beat refill, 5 stall cycles.
      applyStimulus(1'b1, 1'b0, 32'h40, 32'd0, 0);
      checkOutput("cold_miss_cycles", missCycles, 5);
      checkRefill("cold", 32'h40);
      checkOutput("cold_no_wb", wrCount, 0);
      checkOutput("cold_rd_data", lastRdData, 32'h40);
      checkOutput("cold_excl", bothSeen, 0);

      applyStimulus(1'b1, 1'b0, 32'h48, 32'd0, 0);
      checkOutput("hit_miss_cycles", missCycles, 0);
      checkOutput("hit_no_mem", rdCount + wrCount, 0);
      checkOutput("hit_rd_data", lastRdData, 32'h48);

      applyStimulus(1'b0, 1'b1, 32'h44, 32'hDEADBEEF, 0);
      checkOutput("wr_hit_miss_cycles", missCycles, 0);

      // Conflict on index 4 with a dirty victim: writeback then refill, 9 stall cycles.
      applyStimulus(1'b1, 1'b0, 32'hC4, 32'd0, 0);
      expWb = '{32'h40, 32'hDEADBEEF, 32'h48, 32'h4C};
      checkOutput("dirty_miss_cycles", missCycles, 9);
      checkWriteback("dirty", 32'h40);
      checkRefill("dirty", 32'hC0);
      checkOutput("dirty_rd_data", lastRdData, 32'hC4);
      checkOutput("dirty_excl", bothSeen, 0);

      applyStimulus(1'b1, 1'b0, 32'h2C, 32'd0, 3);
      checkOutput("slow_miss_cycles", missCycles, 17);
      checkRefill("slow", 32'h20);
      checkOutput("slow_rd_data", lastRdData, 32'h2C);

      // Line 4 holds 0xC0 clean, so this is a clean refill.
      applyStimulus(1'b1, 1'b0, 32'h48, 32'd0, 0);
      checkOutput("clean_evict_cycles", missCycles, 5);
      checkOutput("clean_evict_no_wb", wrCount, 0);
      checkOutput("clean_evict_rd_data", lastRdData, 32'h48);

      applyStimulus(1'b1, 1'b1, 32'h48, 32'h12345678, 0);
      checkOutput("rdwr_miss_cycles", missCycles, 0);
      applyStimulus(1'b1, 1'b0, 32'h48, 32'd0, 0);
      checkOutput("rdwr_readback", lastRdData, 32'h12345678);
      checkOutput("rdwr_readback_miss", missCycles, 0);

      applyStimulus(1'b1, 1'b0, 32'hC8, 32'd0, 0);
      expWb = '{32'h40, 32'h44, 32'h12345678, 32'h4C};
      checkOutput("rdwr_evict_cycles", missCycles, 9);
      checkWriteback("rdwr_evict", 32'h40);
      checkOutput("rdwr_evict_rd_data", lastRdData, 32'hC8);

      // Make line 4 dirty so the reset below must discard it.
      applyStimulus(1'b0, 1'b1, 32'hC8, 32'hCAFEF00D, 0);
      checkOutput("dirty_before_rst", missCycles, 0);

      // Abort a refill of 0x100 after its second beat.
      bus.rd_req = 1'b1;
      bus.addr   = 32'h100;
      #1;
      checkOutput("abort_req_miss", bus.miss, 1);
      @(posedge clk); #1;
      bus.mem_rd_data = 32'h100;
      bus.mem_gnt     = 1'b1;
      #1;
      checkOutput("abort_beat0_addr", bus.mem_addr, 32'h100);
      @(posedge clk); #1;
      bus.mem_rd_data = 32'h104;
      #1;
      checkOutput("abort_beat1_addr", bus.mem_addr, 32'h104);
      @(posedge clk); #1;
      rst         = 1'b1;
      bus.rd_req  = 1'b0;
      bus.mem_gnt = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checkOutput("abort_mem_rd", bus.mem_rd_req, 0);
      checkOutput("abort_mem_wr", bus.mem_wr_req, 0);
      checkOutput("abort_miss", bus.miss, 0);

      applyStimulus(1'b1, 1'b0, 32'h100, 32'd0, 0);
      checkOutput("reread_cycles", missCycles, 5);
      checkRefill("reread", 32'h100);
      checkOutput("reread_rd_data", lastRdData, 32'h100);

      applyStimulus(1'b1, 1'b0, 32'h48, 32'd0, 0);
      checkOutput("discard_no_wb", wrCount, 0);
      checkOutput("discard_cycles", missCycles, 5);
      checkOutput("discard_rd_data", lastRdData, 32'h48);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
